// File: rtl/ecc_secded_codec.sv
// SECDED Hamming codec: 1-stage registered encoder and 2-stage registered decoder/corrector,
// each with valid/ready flow control, plus saturating SEC/DED counters and fault injection.
module ecc_secded_codec #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned PAR_W  = 6,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enc_vld_i,
  output logic              enc_rdy_o,
  input  logic [DATA_W-1:0] enc_dat_i,
  input  logic [CODE_W-1:0] inj_msk_i,
  output logic              enc_vld_o,
  input  logic              enc_rdy_i,
  output logic [CODE_W-1:0] enc_cw_o,
  input  logic              dec_vld_i,
  output logic              dec_rdy_o,
  input  logic [CODE_W-1:0] dec_cw_i,
  output logic              dec_vld_o,
  input  logic              dec_rdy_i,
  output logic [DATA_W-1:0] dec_dat_o,
  output logic              dec_sec_o,
  output logic              dec_ded_o,
  input  logic              corr_en_i,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  sec_cnt_o,
  output logic [CNT_W-1:0]  ded_cnt_o
);

  // PAR_W must be the smallest p with 2^p >= DATA_W+p+1
  localparam bit PAR_OK = ((2 ** PAR_W) >= (DATA_W + PAR_W + 1)) &&
                          ((2 ** (PAR_W - 1)) < (DATA_W + PAR_W)) &&
                          (DATA_W >= 4) && (DATA_W <= 64);
  generate
    if (!PAR_OK) begin : g_par_chk
      $error("ecc_secded_codec: PAR_W is not the minimal Hamming parity width for DATA_W");
    end
  endgenerate

  function automatic logic is_pow2(input int unsigned v);
    return (v & (v - 1)) == 0;
  endfunction

  // Hamming positions 1..CODE_W-1 map to cw[pos-1]; top bit is overall parity
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] cw;
    logic              acc;
    int unsigned       j;
    cw = '0;
    j  = 0;
    for (int unsigned pos = 3; pos < CODE_W; pos++) begin
      if (!is_pow2(pos)) begin
        cw[pos-1] = d[j];
        j++;
      end
    end
    for (int unsigned k = 0; k < PAR_W; k++) begin
      acc = 1'b0;
      for (int unsigned pos = 1; pos < CODE_W; pos++)
        if (pos[k]) acc ^= cw[pos-1];
      cw[(1 << k) - 1] = acc;
    end
    cw[CODE_W-1] = ^cw[CODE_W-2:0];
    return cw;
  endfunction

  function automatic logic [PAR_W-1:0] syndrome(input logic [CODE_W-1:0] cw);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int unsigned k = 0; k < PAR_W; k++)
      for (int unsigned pos = 1; pos < CODE_W; pos++)
        if (pos[k]) s[k] ^= cw[pos-1];
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int unsigned       j;
    d = '0;
    j = 0;
    for (int unsigned pos = 3; pos < CODE_W; pos++) begin
      if (!is_pow2(pos)) begin
        d[j] = cw[pos-1];
        j++;
      end
    end
    return d;
  endfunction

  // Encode stage
  assign enc_rdy_o = ~enc_vld_o | enc_rdy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_vld_o <= 1'b0;
      enc_cw_o  <= '0;
    end else if (enc_vld_i && enc_rdy_o) begin
      enc_vld_o <= 1'b1;
      enc_cw_o  <= encode(enc_dat_i) ^ inj_msk_i;
    end else if (enc_rdy_i) begin
      enc_vld_o <= 1'b0;
    end
  end

  // Decode stage 1: capture codeword, syndrome and overall parity
  logic              s1_vld;
  logic [CODE_W-1:0] s1_cw;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_par;
  logic              s2_rdy;

  assign s2_rdy    = ~dec_vld_o | dec_rdy_i;
  assign dec_rdy_o = ~s1_vld | s2_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_cw  <= '0;
      s1_syn <= '0;
      s1_par <= 1'b0;
    end else if (dec_vld_i && dec_rdy_o) begin
      s1_vld <= 1'b1;
      s1_cw  <= dec_cw_i;
      s1_syn <= syndrome(dec_cw_i);
      s1_par <= ^dec_cw_i;
    end else if (s2_rdy) begin
      s1_vld <= 1'b0;
    end
  end

  // Stage 2 classification; out-of-range syndromes are treated as uncorrectable
  logic [CODE_W-1:0] flip_c;
  logic [DATA_W-1:0] dat_c;
  logic              sec_c;
  logic              ded_c;

  always_comb begin
    flip_c = '0;
    sec_c  = 1'b0;
    ded_c  = 1'b0;
    if (s1_syn == '0) begin
      sec_c = s1_par;
    end else if (!s1_par || (s1_syn > PAR_W'(CODE_W - 1))) begin
      ded_c = 1'b1;
    end else begin
      sec_c = 1'b1;
      for (int unsigned i = 0; i < CODE_W - 1; i++)
        if (s1_syn == PAR_W'(i + 1)) flip_c[i] = corr_en_i;
    end
    dat_c = extract(s1_cw ^ flip_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_vld_o <= 1'b0;
      dec_dat_o <= '0;
      dec_sec_o <= 1'b0;
      dec_ded_o <= 1'b0;
    end else if (s2_rdy) begin
      dec_vld_o <= s1_vld;
      if (s1_vld) begin
        dec_dat_o <= dat_c;
        dec_sec_o <= sec_c;
        dec_ded_o <= ded_c;
      end
    end
  end

  // Saturating counters of delivered flagged words; clear has priority
  logic deliver;
  assign deliver = dec_vld_o & dec_rdy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt_o <= '0;
      ded_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      sec_cnt_o <= '0;
      ded_cnt_o <= '0;
    end else if (deliver) begin
      if (dec_sec_o && (sec_cnt_o != '1)) sec_cnt_o <= sec_cnt_o + CNT_W'(1);
      if (dec_ded_o && (ded_cnt_o != '1)) ded_cnt_o <= ded_cnt_o + CNT_W'(1);
    end
  end

endmodule
